// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared constants and helpers for the AXI4-Lite register responder
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int REG_ID       = 0;
    localparam int REG_SCRATCH0 = 1;
    localparam int REG_LED      = 2;
    localparam int REG_COUNTER  = 3;

    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] data,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_hold_reg
//  Description : One-entry valid/ready holding register, emptied by i_clear
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_hold_reg
    import axil_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_clear,
    output logic             o_held,
    output logic [WIDTH-1:0] o_data
);

    logic             r_held;
    logic [WIDTH-1:0] r_data;

    // Ready is masked by reset so the master sees no acceptance while held in reset
    assign o_ready = !r_held && !rst;
    assign o_held  = r_held;
    assign o_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else if (i_clear) begin
            r_held <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_held <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axil_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_responder
//  Description : AXI4-Lite slave with ID, scratch, LED and free-running counter
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_responder
    import axil_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] ID_VALUE  = 32'h5A80_0001
) (
    input  logic        AXI_CLK,
    input  logic        RESET,
    input  logic [31:0] AXI_awaddr,
    input  logic [2:0]  AXI_awprot,
    input  logic        AXI_awvalid,
    output logic        AXI_awready,
    input  logic [31:0] AXI_wdata,
    input  logic [3:0]  AXI_wstrb,
    input  logic        AXI_wvalid,
    output logic        AXI_wready,
    output logic [1:0]  AXI_bresp,
    output logic        AXI_bvalid,
    input  logic        AXI_bready,
    input  logic [31:0] AXI_araddr,
    input  logic [2:0]  AXI_arprot,
    input  logic        AXI_arvalid,
    output logic        AXI_arready,
    output logic [31:0] AXI_rdata,
    output logic [1:0]  AXI_rresp,
    output logic        AXI_rvalid,
    input  logic        AXI_rready,
    output logic [3:0]  LED
);

    localparam int          c_IDX_W     = $clog2(NUM_REGS);
    localparam logic [31:0] c_WIN_BYTES = 32'(NUM_REGS * 4);

    logic               w_aw_held, w_w_held, w_commit;
    logic [31:0]        w_aw_addr, w_aw_off, w_ar_off;
    logic [35:0]        w_w_bundle;
    logic [31:0]        w_wr_data;
    logic [3:0]         w_wr_strb;
    logic               w_wr_hit, w_rd_hit, w_ar_hs;
    logic [c_IDX_W-1:0] w_wr_idx, w_rd_idx;
    logic [31:0]        w_rd_val [NUM_REGS];
    logic               w_unused_prot;

    logic               r_bvalid, r_rvalid;
    logic [1:0]         r_bresp, r_rresp;
    logic [31:0]        r_rdata, r_counter;
    logic [3:0]         r_led;

    assign w_unused_prot = ^{AXI_awprot, AXI_arprot};

    // A commit waits for B to drain so a stalled master never loses a response
    assign w_commit = w_aw_held && w_w_held && !r_bvalid;

    axil_hold_reg #(.WIDTH(32)) u_aw_hold (
        .clk     (AXI_CLK),
        .rst     (RESET),
        .i_valid (AXI_awvalid),
        .o_ready (AXI_awready),
        .i_data  (AXI_awaddr),
        .i_clear (w_commit),
        .o_held  (w_aw_held),
        .o_data  (w_aw_addr)
    );

    axil_hold_reg #(.WIDTH(36)) u_w_hold (
        .clk     (AXI_CLK),
        .rst     (RESET),
        .i_valid (AXI_wvalid),
        .o_ready (AXI_wready),
        .i_data  ({AXI_wstrb, AXI_wdata}),
        .i_clear (w_commit),
        .o_held  (w_w_held),
        .o_data  (w_w_bundle)
    );

    assign w_wr_strb = w_w_bundle[35:32];
    assign w_wr_data = w_w_bundle[31:0];

    assign w_aw_off = w_aw_addr - BASE_ADDR;
    assign w_wr_hit = (w_aw_addr >= BASE_ADDR) && (w_aw_off < c_WIN_BYTES);
    assign w_wr_idx = w_aw_off[c_IDX_W+1:2];

    assign w_ar_off = AXI_araddr - BASE_ADDR;
    assign w_rd_hit = (AXI_araddr >= BASE_ADDR) && (w_ar_off < c_WIN_BYTES);
    assign w_rd_idx = w_ar_off[c_IDX_W+1:2];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == REG_ID) begin : g_id
                assign w_rd_val[gi] = ID_VALUE;
            end else if (gi == REG_LED) begin : g_led
                assign w_rd_val[gi] = {28'd0, r_led};
            end else if (gi == REG_COUNTER) begin : g_cnt
                assign w_rd_val[gi] = r_counter;
            end else begin : g_scratch
                logic [31:0] r_val;
                always_ff @(posedge AXI_CLK or posedge RESET) begin
                    if (RESET) begin
                        r_val <= '0;
                    end else if (w_commit && w_wr_hit && (w_wr_idx == c_IDX_W'(gi))) begin
                        r_val <= apply_wstrb(r_val, w_wr_data, w_wr_strb);
                    end
                end
                assign w_rd_val[gi] = r_val;
            end
        end
    endgenerate

    always_ff @(posedge AXI_CLK or posedge RESET) begin
        if (RESET) begin
            r_led     <= '0;
            r_counter <= '0;
        end else begin
            r_counter <= r_counter + 32'd1;
            if (w_commit && w_wr_hit && (w_wr_idx == c_IDX_W'(REG_LED)) && w_wr_strb[0]) begin
                r_led <= w_wr_data[3:0];
            end
        end
    end

    always_ff @(posedge AXI_CLK or posedge RESET) begin
        if (RESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (r_bvalid && AXI_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    assign AXI_arready = !r_rvalid && !RESET;
    assign w_ar_hs     = AXI_arvalid && AXI_arready;

    // Sampled before this edge's write commit lands, so a colliding read sees old data
    always_ff @(posedge AXI_CLK or posedge RESET) begin
        if (RESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_hit ? w_rd_val[w_rd_idx] : 32'd0;
            r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (r_rvalid && AXI_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    assign AXI_bvalid = r_bvalid;
    assign AXI_bresp  = r_bresp;
    assign AXI_rvalid = r_rvalid;
    assign AXI_rdata  = r_rdata;
    assign AXI_rresp  = r_rresp;
    assign LED        = r_led;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_reg_responder
//  Description : Directed and randomized bench for axil_reg_responder
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_reg_responder;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          NREG = 8;
    localparam logic [31:0] IDV  = 32'h5A80_0001;

    logic        AXI_CLK = 1'b0;
    logic        RESET;
    logic [31:0] AXI_awaddr = '0;
    logic [2:0]  AXI_awprot = '0;
    logic        AXI_awvalid = 1'b0;
    logic        AXI_awready;
    logic [31:0] AXI_wdata = '0;
    logic [3:0]  AXI_wstrb = '0;
    logic        AXI_wvalid = 1'b0;
    logic        AXI_wready;
    logic [1:0]  AXI_bresp;
    logic        AXI_bvalid;
    logic        AXI_bready = 1'b0;
    logic [31:0] AXI_araddr = '0;
    logic [2:0]  AXI_arprot = '0;
    logic        AXI_arvalid = 1'b0;
    logic        AXI_arready;
    logic [31:0] AXI_rdata;
    logic [1:0]  AXI_rresp;
    logic        AXI_rvalid;
    logic        AXI_rready = 1'b0;
    logic [3:0]  LED;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    axil_reg_responder #(.BASE_ADDR(BASE), .NUM_REGS(NREG), .ID_VALUE(IDV)) dut (
        .AXI_CLK     (AXI_CLK),
        .RESET       (RESET),
        .AXI_awaddr  (AXI_awaddr),
        .AXI_awprot  (AXI_awprot),
        .AXI_awvalid (AXI_awvalid),
        .AXI_awready (AXI_awready),
        .AXI_wdata   (AXI_wdata),
        .AXI_wstrb   (AXI_wstrb),
        .AXI_wvalid  (AXI_wvalid),
        .AXI_wready  (AXI_wready),
        .AXI_bresp   (AXI_bresp),
        .AXI_bvalid  (AXI_bvalid),
        .AXI_bready  (AXI_bready),
        .AXI_araddr  (AXI_araddr),
        .AXI_arprot  (AXI_arprot),
        .AXI_arvalid (AXI_arvalid),
        .AXI_arready (AXI_arready),
        .AXI_rdata   (AXI_rdata),
        .AXI_rresp   (AXI_rresp),
        .AXI_rvalid  (AXI_rvalid),
        .AXI_rready  (AXI_rready),
        .LED         (LED)
    );

    always #5 AXI_CLK = ~AXI_CLK;
    always @(posedge AXI_CLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no response, expected one within the cycle bound (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [NREG];
    logic [3:0]  m_led = '0;
    logic [31:0] m_cnt = '0;
    logic [31:0] aw_q [$];
    logic [35:0] w_q [$];
    bit          m_bvalid = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    bit          m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic [1:0]  m_rresp = 2'b00;

    function automatic bit in_window(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + NREG * 4);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (word_of(a))
            0:       return IDV;
            2:       return {28'd0, m_led};
            3:       return m_cnt;
            default: return m_mem[word_of(a)];
        endcase
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = word_of(a);
        if (idx == 2) begin
            if (s[0]) m_led = d[3:0];
        end else if (idx == 1 || idx >= 4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        m_led = '0; m_cnt = '0;
        aw_q.delete(); w_q.delete();
        m_bvalid = 1'b0; m_bresp = 2'b00;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    endtask

    task automatic m_step();
        bit ar_hs  = AXI_arvalid && !m_rvalid;
        bit aw_acc = AXI_awvalid && (aw_q.size() == 0);
        bit w_acc  = AXI_wvalid && (w_q.size() == 0);
        bit commit = (aw_q.size() != 0) && (w_q.size() != 0) && !m_bvalid;
        logic [31:0] a;
        logic [35:0] wd;
        if (ar_hs) begin
            m_rvalid = 1'b1;
            m_rdata  = in_window(AXI_araddr) ? m_read(AXI_araddr) : 32'd0;
            m_rresp  = in_window(AXI_araddr) ? 2'b00 : 2'b10;
        end else if (m_rvalid && AXI_rready) begin
            m_rvalid = 1'b0;
        end
        if (commit) begin
            a  = aw_q.pop_front();
            wd = w_q.pop_front();
            if (in_window(a)) m_write(a, wd[31:0], wd[35:32]);
            m_bresp  = in_window(a) ? 2'b00 : 2'b10;
            m_bvalid = 1'b1;
        end else if (m_bvalid && AXI_bready) begin
            m_bvalid = 1'b0;
        end
        if (aw_acc) aw_q.push_back(AXI_awaddr);
        if (w_acc)  w_q.push_back({AXI_wstrb, AXI_wdata});
        m_cnt = m_cnt + 32'd1;
    endtask

    always @(posedge AXI_CLK or posedge RESET) begin
        if (RESET) m_reset();
        else       m_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge AXI_CLK) begin
        chk("awready", 32'(AXI_awready), 32'(!RESET && aw_q.size() == 0));
        chk("wready",  32'(AXI_wready),  32'(!RESET && w_q.size() == 0));
        chk("arready", 32'(AXI_arready), 32'(!RESET && !m_rvalid));
        chk("bvalid",  32'(AXI_bvalid),  32'(m_bvalid));
        if (m_bvalid) chk("bresp", 32'(AXI_bresp), 32'(m_bresp));
        chk("rvalid",  32'(AXI_rvalid),  32'(m_rvalid));
        if (m_rvalid) begin
            chk("rdata", AXI_rdata, m_rdata);
            chk("rresp", 32'(AXI_rresp), 32'(m_rresp));
        end
        chk("led", 32'(LED), 32'(m_led));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge AXI_CLK);
        #1;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                            output int lat, output int unsigned hs_cyc);
        int t = 0;
        data = '0; resp = 2'b11; lat = -1; hs_cyc = 0;
        AXI_araddr = a; AXI_arvalid = 1'b1; AXI_rready = 1'b1;
        forever begin
            @(negedge AXI_CLK);
            if (AXI_arready) break;
            t++;
            if (t > 20) begin
                fail_timeout("ar_accept");
                AXI_arvalid = 1'b0;
                return;
            end
        end
        hs_cyc = cyc;
        tick();
        AXI_arvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge AXI_CLK);
            lat++;
        end while (!AXI_rvalid && lat < 20);
        if (!AXI_rvalid) begin
            fail_timeout("r_valid");
            return;
        end
        data = AXI_rdata; resp = AXI_rresp;
        tick();
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output int lat);
        bit aw_done = 1'b0, w_done = 1'b0;
        int t = 0;
        resp = 2'b11; lat = -1;
        AXI_awaddr = a; AXI_wdata = d; AXI_wstrb = s;
        AXI_awvalid = 1'b1; AXI_wvalid = 1'b1; AXI_bready = 1'b1;
        while (!(aw_done && w_done)) begin
            @(negedge AXI_CLK);
            if (AXI_awvalid && AXI_awready) aw_done = 1'b1;
            if (AXI_wvalid && AXI_wready)   w_done  = 1'b1;
            tick();
            if (aw_done) AXI_awvalid = 1'b0;
            if (w_done)  AXI_wvalid  = 1'b0;
            t++;
            if (t > 20 && !(aw_done && w_done)) begin
                fail_timeout("aw_w_accept");
                AXI_awvalid = 1'b0; AXI_wvalid = 1'b0;
                return;
            end
        end
        lat = 0;
        do begin
            @(negedge AXI_CLK);
            lat++;
        end while (!AXI_bvalid && lat < 20);
        if (!AXI_bvalid) begin
            fail_timeout("b_valid");
            return;
        end
        resp = AXI_bresp;
        tick();
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return BASE + 32'($urandom_range(0, NREG * 4 + 7));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected one before 1 ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v1, v2;
        logic [1:0]  rr, br;
        int          lat;
        int unsigned h1, h2;
        bit          hs_aw, hs_w, hs_ar;
        int          t;

        RESET = 1'b1;
        @(negedge AXI_CLK);
        chk("rst_rdata", AXI_rdata, 32'd0);
        chk("rst_bresp", 32'(AXI_bresp), 32'd0);
        chk("rst_rresp", 32'(AXI_rresp), 32'd0);
        chk("rst_led",   32'(LED), 32'd0);
        chk("rst_awready", 32'(AXI_awready), 32'd0);
        repeat (2) tick();
        RESET = 1'b0;
        #1;
        chk("rel_ready", 32'({AXI_awready, AXI_wready, AXI_arready}), 32'h7);

        // 1: ID read with latency 1
        axi_read(32'h0, v1, rr, lat, h1);
        chk("t1_id", v1, 32'h5A80_0001);
        chk("t1_rresp", 32'(rr), 32'd0);
        chk("t1_rlat", 32'(lat), 32'd1);

        // 2: strobed write, AW and W together
        axi_write(32'h4, 32'hDEAD_BEEF, 4'b0101, br, lat);
        chk("t2_bresp", 32'(br), 32'd0);
        chk("t2_blat", 32'(lat), 32'd2);
        axi_read(32'h4, v1, rr, lat, h1);
        chk("t2_readback", v1, 32'h00AD_00EF);

        // 3: W three cycles ahead of AW
        AXI_bready = 1'b1;
        AXI_wdata = 32'h1234_5678; AXI_wstrb = 4'hF; AXI_wvalid = 1'b1;
        @(negedge AXI_CLK);
        chk("t3_wready_pre", 32'(AXI_wready), 32'd1);
        tick();
        AXI_wvalid = 1'b0;
        @(negedge AXI_CLK);
        chk("t3_wready_low", 32'(AXI_wready), 32'd0);
        tick(); tick();
        AXI_awaddr = 32'h10; AXI_awvalid = 1'b1;
        @(negedge AXI_CLK);
        chk("t3_awready", 32'(AXI_awready), 32'd1);
        tick();
        AXI_awvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge AXI_CLK);
            lat++;
        end while (!AXI_bvalid && lat < 20);
        chk("t3_blat", 32'(lat), 32'd2);
        tick();
        axi_read(32'h10, v1, rr, lat, h1);
        chk("t3_readback", v1, 32'h1234_5678);

        // 4: LED and read-only counter
        axi_write(32'h8, 32'h0000_00FF, 4'hF, br, lat);
        chk("t4_led", 32'(LED), 32'hF);
        axi_read(32'h8, v1, rr, lat, h1);
        chk("t4_led_read", v1, 32'h0000_000F);
        axi_read(32'hC, v1, rr, lat, h1);
        axi_write(32'hC, 32'hFFFF_FFFF, 4'hF, br, lat);
        chk("t4_ro_bresp", 32'(br), 32'd0);
        axi_read(32'hC, v2, rr, lat, h2);
        chk("t4_cnt_delta", v2 - v1, 32'(h2 - h1));

        // 5: decode boundary
        axi_read(BASE + NREG * 4, v1, rr, lat, h1);
        chk("t5_miss_rresp", 32'(rr), 32'd2);
        chk("t5_miss_rdata", v1, 32'd0);
        axi_write(BASE + NREG * 4, 32'hFFFF_FFFF, 4'hF, br, lat);
        chk("t5_miss_bresp", 32'(br), 32'd2);
        axi_read(BASE + NREG * 4 - 4, v1, rr, lat, h1);
        chk("t5_last_rresp", 32'(rr), 32'd0);
        chk("t5_last_rdata", v1, 32'd0);
        axi_read(32'h4, v1, rr, lat, h1);
        chk("t5_unchanged", v1, 32'h00AD_00EF);

        // 6: B back-pressure, second write parked, then reset
        AXI_bready = 1'b0;
        AXI_awaddr = 32'h14; AXI_wdata = 32'hCAFE_F00D; AXI_wstrb = 4'hF;
        AXI_awvalid = 1'b1; AXI_wvalid = 1'b1;
        tick();
        AXI_awvalid = 1'b0; AXI_wvalid = 1'b0;
        t = 0;
        do begin
            @(negedge AXI_CLK);
            t++;
            if (!AXI_bvalid) tick();
        end while (!AXI_bvalid && t < 20);
        if (!AXI_bvalid) fail_timeout("t6_b_valid");
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge AXI_CLK);
            chk("t6_bvalid_hold", 32'(AXI_bvalid), 32'd1);
            tick();
        end
        AXI_awaddr = 32'h18; AXI_wdata = 32'h0BAD_CAFE;
        AXI_awvalid = 1'b1; AXI_wvalid = 1'b1;
        @(negedge AXI_CLK);
        chk("t6_second_ready", 32'({AXI_awready, AXI_wready}), 32'h3);
        tick();
        AXI_awvalid = 1'b0; AXI_wvalid = 1'b0;
        @(negedge AXI_CLK);
        chk("t6_second_held", 32'({AXI_awready, AXI_wready}), 32'h0);
        chk("t6_first_b_only", 32'({AXI_bvalid, AXI_bresp}), 32'h4);
        tick();
        RESET = 1'b1;
        #1;
        chk("t6_rst_bvalid", 32'(AXI_bvalid), 32'd0);
        chk("t6_rst_led", 32'(LED), 32'd0);
        chk("t6_rst_awready", 32'(AXI_awready), 32'd0);
        tick(); tick();
        RESET = 1'b0;
        AXI_bready = 1'b1;
        #1;
        chk("t6_rel_ready", 32'({AXI_awready, AXI_wready, AXI_arready}), 32'h7);
        axi_read(32'h14, v1, rr, lat, h1);
        chk("t6_scratch_cleared", v1, 32'd0);
        axi_read(32'h18, v1, rr, lat, h1);
        chk("t6_dropped_write", v1, 32'd0);

        // randomized traffic, with one mid-run reset
        for (int c = 0; c < 2000; c++) begin
            @(negedge AXI_CLK);
            hs_aw = AXI_awvalid && AXI_awready;
            hs_w  = AXI_wvalid && AXI_wready;
            hs_ar = AXI_arvalid && AXI_arready;
            tick();
            if (c == 1000) begin
                RESET = 1'b1;
                AXI_awvalid = 1'b0; AXI_wvalid = 1'b0; AXI_arvalid = 1'b0;
                tick(); tick();
                RESET = 1'b0;
                continue;
            end
            if (!AXI_awvalid || hs_aw) begin
                AXI_awvalid = ($urandom_range(0, 2) == 0);
                AXI_awaddr  = rnd_addr();
            end
            if (!AXI_wvalid || hs_w) begin
                AXI_wvalid = ($urandom_range(0, 2) == 0);
                AXI_wdata  = $urandom;
                AXI_wstrb  = 4'($urandom_range(0, 15));
            end
            if (!AXI_arvalid || hs_ar) begin
                AXI_arvalid = ($urandom_range(0, 1) == 0);
                AXI_araddr  = rnd_addr();
            end
            AXI_bready = ($urandom_range(0, 3) != 0);
            AXI_rready = ($urandom_range(0, 3) != 0);
        end
        @(negedge AXI_CLK);
        tick();
        AXI_awvalid = 1'b0; AXI_wvalid = 1'b0; AXI_arvalid = 1'b0;
        AXI_bready = 1'b1; AXI_rready = 1'b1;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
